neuron_output_collector: RTL and testbench

NEURON_OUTPUT_COLLECTOR -- requirements
Module: neuron_output_collector

---
 rtl/neuron_output_collector_pkg.sv | 15 +
 rtl/neuron_output_collector_fifo.sv | 64 ++++++
 rtl/neuron_output_collector.sv | 93 +++++++++
 tb/tb_neuron_output_collector.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/neuron_output_collector_pkg.sv
// Shared widths, default adder-tree latency and the activation helper
// for the neuron output collector.
package neuron_output_collector_pkg;

    localparam int WORD_W                = 26;
    localparam int TREE_PRODUCTS         = 28;
    localparam int TREE_LATENCY_DEFAULT  = 10;

    // ReLU on a two's-complement word: negative values clamp to zero.
    function automatic logic [WORD_W-1:0] activate(input logic [WORD_W-1:0] x,
                                                   input logic              relu_en);
        return (relu_en && x[WORD_W-1]) ? '0 : x;
    endfunction

endpackage

// File: rtl/neuron_output_collector_fifo.sv
// First-word fall-through result FIFO; full/empty come from an explicit
// count so any DEPTH (not only powers of two) works.
module result_fifo #(
    parameter int WIDTH = 26,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign count    = count_q;
    assign pop_data = mem[rd_ptr];
    assign do_pop   = pop && !empty;
    // A full FIFO can still take a write when the head leaves in the same cycle.
    assign do_push  = push && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_next(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/neuron_output_collector.sv
// Collects adder-tree sums: tracks issued operands through the tree latency,
// applies the activation and buffers results with credit-based flow control.
module neuron_output_collector
    import neuron_output_collector_pkg::*;
#(
    parameter int TREE_LATENCY = TREE_LATENCY_DEFAULT,
    parameter int DEPTH        = 4,
    parameter bit RELU_EN      = 1'b1
) (
    input  logic                       clk,
    input  logic                       GlobalReset,
    input  logic                       InValid,
    output logic                       InReady,
    input  logic [WORD_W-1:0]          Result_1,
    output logic [WORD_W-1:0]          OutData,
    output logic                       OutValid,
    input  logic                       OutReady,
    output logic                       Overflow,
    output logic [$clog2(DEPTH+1)-1:0] Occupancy
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [TREE_LATENCY-1:0] valid_sr;
    logic                    tap_valid;
    logic                    accept;
    logic                    violation;
    logic                    pop;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [OCC_W-1:0]        fifo_count;
    logic [OCC_W-1:0]        occ_q;
    logic [OCC_W-1:0]        occ_next;
    logic                    in_ready_q;
    logic                    overflow_q;

    assign accept    = InValid && in_ready_q;
    assign violation = InValid && !in_ready_q;
    assign tap_valid = valid_sr[TREE_LATENCY-1];
    assign pop       = !fifo_empty && OutReady;

    always_comb begin
        occ_next = occ_q;
        case ({accept, pop})
            2'b10:   occ_next = occ_q + 1'b1;
            2'b01:   occ_next = occ_q - 1'b1;
            default: occ_next = occ_q;
        endcase
    end

    // InReady is registered from the next occupancy so it never follows OutReady combinationally.
    always_ff @(posedge clk or posedge GlobalReset) begin
        if (GlobalReset) begin
            valid_sr   <= '0;
            occ_q      <= '0;
            in_ready_q <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            valid_sr   <= {valid_sr[TREE_LATENCY-2:0], accept};
            occ_q      <= occ_next;
            in_ready_q <= (occ_next < OCC_W'(DEPTH));
            overflow_q <= overflow_q || violation || (tap_valid && fifo_full && !pop);
        end
    end

    // Stored results are always a subset of the credits held.
    always_ff @(posedge clk) begin
        if (!GlobalReset) begin
            assert (fifo_count <= occ_q);
        end
    end

    result_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (GlobalReset),
        .push      (tap_valid),
        .push_data (activate(Result_1, RELU_EN)),
        .pop       (pop),
        .pop_data  (OutData),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign InReady   = in_ready_q;
    assign OutValid  = !fifo_empty;
    assign Overflow  = overflow_q;
    assign Occupancy = occ_q;

endmodule

// File: tb/tb_neuron_output_collector.sv
// Directed bench: a delay-line model of the adder tree feeds three collector
// instances (default, pass-through activation, deep FIFO for streaming).
module tb_neuron_output_collector;
    import neuron_output_collector_pkg::*;

    localparam int TL = TREE_LATENCY_DEFAULT;
    localparam logic [25:0] GARB = 26'h2AAAAAA;

    logic        clk;
    logic        GlobalReset;
    logic        in_valid;
    logic        in_valid_deep;
    logic        out_ready;
    logic [25:0] payload;
    logic [25:0] tree_pipe [TL];
    logic [25:0] result_1;

    logic        in_ready, out_valid, overflow;
    logic [25:0] out_data;
    logic [2:0]  occupancy;
    logic        nr_in_ready, nr_out_valid, nr_overflow;
    logic [25:0] nr_out_data;
    logic [2:0]  nr_occupancy;
    logic        dp_in_ready, dp_out_valid, dp_overflow;
    logic [25:0] dp_out_data;
    logic [4:0]  dp_occupancy;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        logic [25:0] res;
        logic [25:0] exp_relu;
        logic [25:0] exp_pass;
    } vec_t;
    vec_t vecs [6];

    neuron_output_collector dut (
        .clk(clk), .GlobalReset(GlobalReset), .InValid(in_valid), .InReady(in_ready),
        .Result_1(result_1), .OutData(out_data), .OutValid(out_valid),
        .OutReady(out_ready), .Overflow(overflow), .Occupancy(occupancy));

    neuron_output_collector #(.RELU_EN(1'b0)) dut_nr (
        .clk(clk), .GlobalReset(GlobalReset), .InValid(in_valid), .InReady(nr_in_ready),
        .Result_1(result_1), .OutData(nr_out_data), .OutValid(nr_out_valid),
        .OutReady(out_ready), .Overflow(nr_overflow), .Occupancy(nr_occupancy));

    neuron_output_collector #(.DEPTH(16)) dut_deep (
        .clk(clk), .GlobalReset(GlobalReset), .InValid(in_valid_deep), .InReady(dp_in_ready),
        .Result_1(result_1), .OutData(dp_out_data), .OutValid(dp_out_valid),
        .OutReady(out_ready), .Overflow(dp_overflow), .Occupancy(dp_occupancy));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Adder-tree model: payload sampled with InValid appears on Result_1 TL cycles later.
    always @(posedge clk) begin
        tree_pipe[0] <= payload;
        for (int i = 1; i < TL; i++) tree_pipe[i] <= tree_pipe[i-1];
    end
    assign result_1 = tree_pipe[TL-1];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [25:0] v);
        in_valid = 1'b1;
        payload  = v;
        tick();
        in_valid = 1'b0;
        payload  = GARB;
    endtask

    logic [25:0] exp_q [4];

    initial begin
        vecs[0] = '{26'h0000123, 26'h0000123, 26'h0000123};
        vecs[1] = '{26'h3FFFF00, 26'h0000000, 26'h3FFFF00};
        vecs[2] = '{26'h1FFFFFF, 26'h1FFFFFF, 26'h1FFFFFF};
        vecs[3] = '{26'h2000000, 26'h0000000, 26'h2000000};
        vecs[4] = '{26'h0000000, 26'h0000000, 26'h0000000};
        vecs[5] = '{26'h3FFFFFF, 26'h0000000, 26'h3FFFFFF};

        GlobalReset   = 1'b1;
        in_valid      = 1'b0;
        in_valid_deep = 1'b0;
        out_ready     = 1'b1;
        payload       = GARB;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_occupancy", occupancy, 0);
        GlobalReset = 1'b0;
        tick();

        // Single ops through the full latency, both activation settings.
        for (int v = 0; v < 6; v++) begin
            issue(vecs[v].res);
            chk("single_occ_inflight", occupancy, 1);
            repeat (TL - 1) tick();
            chk("single_early_valid", out_valid, 0);
            tick();
            chk("single_valid", out_valid, 1);
            chk("single_data_relu", out_data, vecs[v].exp_relu);
            chk("single_data_pass", nr_out_data, vecs[v].exp_pass);
            chk("single_occ_held", occupancy, 1);
            tick();
            chk("single_valid_after_pop", out_valid, 0);
            chk("single_occ_after_pop", occupancy, 0);
            chk("single_in_ready", in_ready, 1);
        end

        // Backpressure with a well-behaved upstream: exactly DEPTH credits.
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("bp_in_ready", in_ready, (i < 4) ? 1 : 0);
            in_valid = in_ready;
            payload  = 26'h0055000 + 26'(i);
            tick();
        end
        in_valid = 1'b0;
        payload  = GARB;
        chk("bp_occ_full", occupancy, 4);
        repeat (7) tick();
        chk("bp_stored_valid", out_valid, 1);
        chk("bp_overflow", overflow, 0);
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            chk("bp_drain_valid", out_valid, 1);
            chk("bp_drain_data", out_data, 26'h0055000 + 26'(j));
            tick();
        end
        chk("bp_empty", out_valid, 0);
        chk("bp_occ_zero", occupancy, 0);
        chk("bp_in_ready_back", in_ready, 1);
        chk("bp_overflow_end", overflow, 0);

        // Streaming on the deep instance: 20 results on consecutive cycles 10..29.
        for (int t = 0; t < 32; t++) begin
            in_valid_deep = (t < 20);
            payload       = (t < 20) ? 26'h0100000 + 26'(t * 7) : GARB;
            tick();
            chk("stream_valid", dp_out_valid, (t >= TL && t < TL + 20) ? 1 : 0);
            if (t >= TL && t < TL + 20)
                chk("stream_data", dp_out_data, 26'h0100000 + 26'((t - TL) * 7));
        end
        in_valid_deep = 1'b0;
        chk("stream_occ_end", dp_occupancy, 0);
        chk("stream_overflow", dp_overflow, 0);

        // Protocol violation while full: ignored, sticky Overflow, contents intact.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_q[i] = 26'h0ABC000 + 26'(i);
            issue(exp_q[i]);
        end
        repeat (11) tick();
        chk("viol_pre_in_ready", in_ready, 0);
        chk("viol_pre_occ", occupancy, 4);
        chk("viol_pre_overflow", overflow, 0);
        issue(26'h1234567);
        chk("viol_overflow_set", overflow, 1);
        chk("viol_occ_same", occupancy, 4);
        repeat (12) tick();
        chk("viol_overflow_sticky", overflow, 1);
        chk("viol_occ_later", occupancy, 4);
        chk("viol_head", out_data, exp_q[0]);
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            chk("viol_drain_valid", out_valid, 1);
            chk("viol_drain_data", out_data, exp_q[j]);
            tick();
        end
        chk("viol_no_extra", out_valid, 0);
        chk("viol_occ_zero", occupancy, 0);
        chk("viol_overflow_after_drain", overflow, 1);

        // Reset mid-flight discards everything.
        issue(26'h0000111);
        issue(26'h0000222);
        issue(26'h0000333);
        repeat (3) tick();
        chk("midrst_occ_before", occupancy, 3);
        GlobalReset = 1'b1;
        #2;
        chk("midrst_async_occ", occupancy, 0);
        chk("midrst_async_in_ready", in_ready, 1);
        chk("midrst_async_overflow", overflow, 0);
        GlobalReset = 1'b0;
        for (int t = 0; t < 15; t++) begin
            tick();
            chk("midrst_no_valid", out_valid, 0);
        end
        chk("midrst_occ", occupancy, 0);
        chk("midrst_in_ready", in_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
